turn_ctrl_m: RTL and testbench
==============================

# turn_ctrl_m

Game sequencer between the player and AI move sources and the board. Owns the `turn` flag, which steers the player/AI tri-state drivers. Accepts one move per turn from the side whose turn it is, rejects illegal moves, and issues a single write to the board per legal move. Tracks occupancy, detects a win or a tie, and optionally forfeits a side that stalls.

## Interface
Parameters:
- `FIRST_TURN`, 0: side that moves first after `start` (0 = `TURN_PLAYER`, 1 = `TURN_AI`).
- `TIMEOUT_CYCLES`, 1024: per-move stall limit; used only with `TURN_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a game; honored only in IDLE.
- `new_game`  in  1  synchronous abort; returns to IDLE from any state.
- `move_loc`  in  4  shared move bus (tri-stated by player/AI); cell 0..8, row-major.
- `move_submit`  in  1  shared submit strobe, qualified by `turn`.
- `turn`  out  1  0 = player drives the bus, 1 = AI drives the bus.
- `board_we`  out  1  one-cycle board write strobe.
- `board_loc`  out  4  cell being written; valid only while `board_we`=1.
- `board_mark`  out  1  mark written (0 = player, 1 = AI).
- `illegal`  out  1  one-cycle pulse when a submitted move is rejected.
- `move_count`  out  4  legal moves committed this game (0..9).
- `game_over`  out  1  high in DONE.
- `winner`  out  2  00 = none, 01 = player, 10 = AI, 11 = tie.

## Operation
- Internal state: `occ_p[8:0]` and `occ_a[8:0]`, one occupancy bit per cell for each side.
- IDLE: occupancy cleared, `move_count`=0. When `start`=1: `turn`<=`FIRST_TURN`, go to WAIT.
- WAIT: sample `move_submit`/`move_loc` each cycle.
  - Legal move: `move_loc`<=8 and the cell is free in both maps. Latch loc, set the current side's occupancy bit, `move_count`+1, go to COMMIT.
  - Illegal move: `illegal` pulses for 1 cycle; stay in WAIT; `turn` is unchanged.
  - `move_submit` is ignored in every state except WAIT.
- COMMIT: `board_we`=1, `board_loc`=latched loc, `board_mark`=`turn`. Go to CHECK.
- CHECK: evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the mover's map.
  - Line complete: `winner`=mover (01 or 10), go to DONE.
  - Else `move_count`=9: `winner`=11, go to DONE.
  - Else: toggle `turn`, go to WAIT.
- DONE: `game_over`=1; outputs hold. Only `new_game` (or reset) exits.
- `new_game` has priority over every other input in every state. It clears occupancy, `move_count`, `winner`, and `game_over`. `turn`<=`FIRST_TURN`. Next state is IDLE.
- `start` asserted outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE; `turn`=`FIRST_TURN`.
  - `board_we`=0, `board_loc`=0, `board_mark`=0.
  - `illegal`=0, `move_count`=0, `game_over`=0, `winner`=00.
  - Occupancy cleared.
- Submit sampled on edge N (WAIT) → `board_we` high in cycle N+1 → `turn` toggles (or `game_over` rises) at edge N+2.
- Minimum turn period: 3 cycles.
- The driving side must deassert `move_submit` before `turn` returns to it. A submit held high across a turn hand-off is a protocol violation; the block does not filter it.
- `illegal` is asserted in cycle N+1 relative to the rejected sample.
- Reset mid-move (e.g. during COMMIT) drops the pending write: `board_we` goes low immediately and asynchronously.
- `move_count` is 4 bits wide and saturates at 9 by construction; it never wraps.
- A win and a full board on the same move report the win, not the tie.

## Configuration
- `TURN_TIMEOUT_EN` defined:
  - A 16-bit counter runs in WAIT and clears on every legal submit.
  - Reaching `TIMEOUT_CYCLES`-1 forfeits the game: `winner`=opponent, go to DONE with no board write.
  - Illegal submits do not clear the counter.
- `TURN_TIMEOUT_EN` undefined: no counter is built; WAIT waits indefinitely.

## Test plan
- Player wins. Reset, `start`; player 0, AI 3, player 1, AI 4, player 2. Expect 5 `board_we` pulses with loc 0,3,1,4,2 and mark 0,1,0,1,0; then `winner`=01, `game_over`=1, `move_count`=5.
- Tie. Moves 4,0,8,2,1,7,3,5,6 (alternating, player first). Expect `winner`=11, `move_count`=9, 9 writes.
- Illegal moves. Player 4 is committed; AI submits 4, then 9. Expect `illegal` to pulse twice, no `board_we`, `turn` stays 1. AI then submits 0 and it is accepted.
- Abort mid-game. `new_game` asserted in the CHECK cycle after move 3. Next cycle: IDLE, `move_count`=0, `turn`=`FIRST_TURN`; no further writes.
- Async reset. `rst_n` pulled low during COMMIT. `board_we` falls without waiting for a clock edge; all outputs take their reset values.
- Timeout (`TURN_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8). The AI never submits after player 4. Expect `winner`=01 and `game_over`=1 eight cycles after entering WAIT; the AI's turn produces no `board_we`.

Source files
------------

// File: rtl/turn_ctrl_m.sv
// Tic-tac-toe turn sequencer: arbitrates player/AI moves, commits legal ones to the board, detects win/tie.
// Optional per-move stall forfeit is built when TURN_TIMEOUT_EN is defined.
module turn_ctrl_m #(
  parameter int unsigned FIRST_TURN     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       new_game,
  input  logic [3:0] move_loc,
  input  logic       move_submit,
  output logic       turn,
  output logic       board_we,
  output logic [3:0] board_loc,
  output logic       board_mark,
  output logic       illegal,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_COMMIT, S_CHECK, S_DONE
  } state_e;

  localparam logic FIRST_MARK = FIRST_TURN[0];

  if (FIRST_TURN > 1 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("turn_ctrl_m: FIRST_TURN must be 0/1 and TIMEOUT_CYCLES within 2..65536");
  end

  state_e      state_q, state_d;
  logic        turn_q, turn_d;
  logic [8:0]  occ_p_q, occ_p_d;
  logic [8:0]  occ_a_q, occ_a_d;
  logic [3:0]  loc_q, loc_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  winner_q, winner_d;
  logic        illegal_q, illegal_d;
  logic [8:0]  cell_onehot;
  logic        legal;
  logic        line_done;

`ifdef TURN_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q, tmo_d;
`endif

  function automatic logic has_line(input logic [8:0] m);
    return (&m[2:0]) | (&m[5:3]) | (&m[8:6]) |
           (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
           (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
  endfunction

  // Shifting past bit 8 drops the one, so off-board locations map to an empty mask.
  assign cell_onehot = 9'd1 << move_loc;
  assign legal       = (move_loc <= 4'd8) && (((occ_p_q | occ_a_q) & cell_onehot) == 9'd0);
  assign line_done   = has_line(turn_q ? occ_a_q : occ_p_q);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    occ_p_d   = occ_p_q;
    occ_a_d   = occ_a_q;
    loc_d     = loc_q;
    count_d   = count_q;
    winner_d  = winner_q;
    illegal_d = 1'b0;
`ifdef TURN_TIMEOUT_EN
    tmo_d     = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        occ_p_d = '0;
        occ_a_d = '0;
        count_d = '0;
        if (start) begin
          turn_d  = FIRST_MARK;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (move_submit && legal) begin
          loc_d   = move_loc;
          count_d = count_q + 4'd1;
          state_d = S_COMMIT;
          if (turn_q) occ_a_d = occ_a_q | cell_onehot;
          else        occ_p_d = occ_p_q | cell_onehot;
        end else begin
          illegal_d = move_submit;
`ifdef TURN_TIMEOUT_EN
          // The stalling side forfeits; the opponent is credited without a board write.
          if (tmo_q == TMO_LAST) begin
            winner_d = turn_q ? 2'b01 : 2'b10;
            state_d  = S_DONE;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
`endif
        end
      end
      S_COMMIT: state_d = S_CHECK;
      S_CHECK: begin
        if (line_done) begin
          winner_d = turn_q ? 2'b10 : 2'b01;
          state_d  = S_DONE;
        end else if (count_q == 4'd9) begin
          winner_d = 2'b11;
          state_d  = S_DONE;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_WAIT;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (new_game) begin
      state_d   = S_IDLE;
      turn_d    = FIRST_MARK;
      occ_p_d   = '0;
      occ_a_d   = '0;
      count_d   = '0;
      winner_d  = 2'b00;
      illegal_d = 1'b0;
`ifdef TURN_TIMEOUT_EN
      tmo_d     = '0;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      turn_q    <= FIRST_MARK;
      occ_p_q   <= '0;
      occ_a_q   <= '0;
      loc_q     <= '0;
      count_q   <= '0;
      winner_q  <= 2'b00;
      illegal_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      occ_p_q   <= occ_p_d;
      occ_a_q   <= occ_a_d;
      loc_q     <= loc_d;
      count_q   <= count_d;
      winner_q  <= winner_d;
      illegal_q <= illegal_d;
`ifdef TURN_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Write outputs decode straight from state so an async reset kills a pending write at once.
  assign board_we   = (state_q == S_COMMIT);
  assign board_loc  = board_we ? loc_q : 4'd0;
  assign board_mark = board_we & turn_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign move_count = count_q;
  assign game_over  = (state_q == S_DONE);
  assign winner     = winner_q;

endmodule

// File: tb/tb_turn_ctrl_m.sv
// Directed self-checking bench for turn_ctrl_m: win, tie, illegal moves, abort, async reset,
// and (when TURN_TIMEOUT_EN is defined) stall forfeit with TIMEOUT_CYCLES=8.
module tb_turn_ctrl_m;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] move_loc = 4'd0;
  logic       move_submit = 1'b0;
  logic       turn, board_we, board_mark, illegal, game_over;
  logic [3:0] board_loc, move_count;
  logic [1:0] winner;

  int n_checks = 0;
  int n_pass   = 0;
  int we_count = 0;

  turn_ctrl_m #(.FIRST_TURN(0), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .new_game(new_game),
    .move_loc(move_loc), .move_submit(move_submit), .turn(turn),
    .board_we(board_we), .board_loc(board_loc), .board_mark(board_mark),
    .illegal(illegal), .move_count(move_count), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (board_we) we_count++;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic restart();
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0; start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Leaves the bench sampling in the COMMIT cycle of the submitted move.
  task automatic send(input logic [3:0] loc);
    @(negedge clk) move_submit = 1'b1; move_loc = loc;
    @(negedge clk) move_submit = 1'b0;
  endtask

  task automatic play(input logic [3:0] loc, input logic mark);
    send(loc);
    check("we", board_we, 1);
    check("loc", board_loc, loc);
    check("mark", board_mark, mark);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic reject(input logic [3:0] loc);
    int w0;
    w0 = we_count;
    send(loc);
    check("illegal_pulse", illegal, 1);
    check("illegal_no_we", we_count, w0);
    check("illegal_turn", turn, 1);
    @(negedge clk);
    check("illegal_one_cycle", illegal, 0);
  endtask

  initial begin
    logic [3:0] tie_seq [9] = '{4'd4, 4'd0, 4'd8, 4'd2, 4'd1, 4'd7, 4'd3, 4'd5, 4'd6};
    int w0;

    // Reset values
    #12;
    check("rst_turn", turn, 0);
    check("rst_we", board_we, 0);
    check("rst_loc", board_loc, 0);
    check("rst_mark", board_mark, 0);
    check("rst_illegal", illegal, 0);
    check("rst_count", move_count, 0);
    check("rst_over", game_over, 0);
    check("rst_winner", winner, 0);
    @(negedge clk) rst_n = 1'b1;

    // Submits while IDLE are ignored
    send(4'd3);
    check("idle_no_we", board_we, 0);
    check("idle_count", move_count, 0);

    // Player wins on the top row
    restart();
    play(4'd0, 1'b0); check("pw_turn1", turn, 1);
    play(4'd3, 1'b1); check("pw_turn2", turn, 0);
    play(4'd1, 1'b0);
    play(4'd4, 1'b1);
    play(4'd2, 1'b0);
    check("pw_winner", winner, 1);
    check("pw_over", game_over, 1);
    check("pw_count", move_count, 5);
    check("pw_writes", we_count, 5);
    // Start is ignored in DONE and outputs hold
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("done_hold", game_over, 1);

    // Tie: full board, no line
    w0 = we_count;
    restart();
    check("ng_winner_clr", winner, 0);
    for (int i = 0; i < 9; i++) play(tie_seq[i], 1'(i % 2));
    check("tie_winner", winner, 3);
    check("tie_count", move_count, 9);
    check("tie_writes", we_count - w0, 9);
    check("tie_over", game_over, 1);

    // Illegal moves on the AI's turn
    restart();
    play(4'd4, 1'b0);
    reject(4'd4);
    reject(4'd9);
    check("illegal_count", move_count, 1);
    play(4'd0, 1'b1);
    check("legal_after", move_count, 2);
    check("turn_back", turn, 0);

    // Abort in the CHECK cycle of move 3
    restart();
    play(4'd0, 1'b0);
    play(4'd1, 1'b1);
    send(4'd5);
    check("ab_we", board_we, 1);
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    check("ab_count", move_count, 0);
    check("ab_turn", turn, 0);
    check("ab_over", game_over, 0);
    w0 = we_count;
    repeat (3) @(negedge clk);
    check("ab_no_write", we_count, w0);

    // Async reset during COMMIT
    restart();
    play(4'd0, 1'b0);
    send(4'd8);
    check("ar_we_before", board_we, 1);
    check("ar_mark_before", board_mark, 1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_we_async", board_we, 0);
    check("ar_loc", board_loc, 0);
    check("ar_mark", board_mark, 0);
    check("ar_turn", turn, 0);
    check("ar_count", move_count, 0);
    check("ar_winner", winner, 0);
    @(negedge clk) rst_n = 1'b1;

`ifdef TURN_TIMEOUT_EN
    // AI stalls after the player's move and forfeits 8 cycles into WAIT
    restart();
    play(4'd4, 1'b0);
    w0 = we_count;
    repeat (7) @(negedge clk);
    check("to_not_yet", game_over, 0);
    @(negedge clk);
    check("to_over", game_over, 1);
    check("to_winner", winner, 1);
    check("to_no_write", we_count, w0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
